// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if
// Groups the signals between the Flappy Bird game sequencer and the rest of
// the datapath.
//   Inputs to the sequencer : flap, pause_sw, collide, out_of_bounds
//   Outputs of the sequencer: state[1:0], round_clr, flap_en, gravity_en,
//                             scroll_en, spawn_en, hs_commit, blank
// Modports:
//   slave  - the sequencer itself (consumes inputs, drives controls)
//   master - the surrounding logic / testbench (drives inputs, sees controls)
// ---------------------------------------------------------------------------
interface game_sequencer_if;
  logic       flap;
  logic       pause_sw;
  logic       collide;
  logic       out_of_bounds;
  logic [1:0] state;
  logic       round_clr;
  logic       flap_en;
  logic       gravity_en;
  logic       scroll_en;
  logic       spawn_en;
  logic       hs_commit;
  logic       blank;

  modport slave (
    input  flap, pause_sw, collide, out_of_bounds,
    output state, round_clr, flap_en, gravity_en, scroll_en, spawn_en,
           hs_commit, blank
  );

  modport master (
    output flap, pause_sw, collide, out_of_bounds,
    input  state, round_clr, flap_en, gravity_en, scroll_en, spawn_en,
           hs_commit, blank
  );
endinterface

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
// Top-level game controller for the 8x8 Flappy Bird datapath. A single FSM
// (IDLE/PLAY/PAUSED/OVER) generates the gravity, scroll and spawn ticks, the
// round-clear level, the gated flap, a one-shot high-score commit and the
// game-over blink. Every output is registered.
//
// Ports:
//   clk    - divided system clock
//   reset  - synchronous, active-low reset (0 = reset)
//   bus    - game_sequencer_if.slave (flap/pause_sw/collide/out_of_bounds in;
//            state/round_clr/flap_en/gravity_en/scroll_en/spawn_en/
//            hs_commit/blank out)
//
// Optional feature (macro SEQ_SPEEDUP_EN): when defined, the scroll period
// starts at SCROLL_DIV, shrinks by one after every 8 spawn ticks down to a
// floor of SCROLL_DIV/2, and returns to SCROLL_DIV whenever round_clr is set.
// When undefined the scroll period is the constant SCROLL_DIV.
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int GRAVITY_DIV = 8,
  parameter int SCROLL_DIV  = 24,
  parameter int SPAWN_DIV   = 4,
  parameter int OVER_HOLD   = 64,
  parameter int BLINK_DIV   = 8
) (
  input  logic             clk,
  input  logic             reset,
  game_sequencer_if.slave  bus
);

  localparam int GW = $clog2(GRAVITY_DIV) + 1;
  localparam int SW = $clog2(SCROLL_DIV) + 1;
  localparam int PW = $clog2(SPAWN_DIV) + 1;
  localparam int HW = $clog2(OVER_HOLD) + 1;
  localparam int BW = $clog2(BLINK_DIV) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t          st_q, st_d;
  logic [GW-1:0]   grav_q, grav_d;
  logic [SW-1:0]   scroll_q, scroll_d;
  logic [PW-1:0]   spawn_q, spawn_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            round_clr_q, round_clr_d;
  logic            flap_en_q, flap_en_d;
  logic            gravity_en_q, gravity_en_d;
  logic            scroll_en_q, scroll_en_d;
  logic            spawn_en_q, spawn_en_d;
  logic            hs_commit_q, hs_commit_d;
  logic            blank_q, blank_d;
  logic            crash;
  logic [SW-1:0]   scroll_last;

`ifdef SEQ_SPEEDUP_EN
  logic [SW-1:0]   period_q, period_d;
  logic [2:0]      speed_cnt_q, speed_cnt_d;

  // The scroll counter wraps one below the current (shrinking) period.
  assign scroll_last = period_q - SW'(1);
`else
  assign scroll_last = SW'(SCROLL_DIV - 1);
`endif

  assign crash = bus.collide | bus.out_of_bounds;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it only acts on a rising clock edge.
    if (!reset) begin
      st_q         <= IDLE;
      grav_q       <= '0;
      scroll_q     <= '0;
      spawn_q      <= '0;
      hold_q       <= '0;
      blink_q      <= '0;
      round_clr_q  <= 1'b1;
      flap_en_q    <= 1'b0;
      gravity_en_q <= 1'b0;
      scroll_en_q  <= 1'b0;
      spawn_en_q   <= 1'b0;
      hs_commit_q  <= 1'b0;
      blank_q      <= 1'b0;
`ifdef SEQ_SPEEDUP_EN
      period_q     <= SW'(SCROLL_DIV);
      speed_cnt_q  <= '0;
`endif
    end else begin
      st_q         <= st_d;
      grav_q       <= grav_d;
      scroll_q     <= scroll_d;
      spawn_q      <= spawn_d;
      hold_q       <= hold_d;
      blink_q      <= blink_d;
      round_clr_q  <= round_clr_d;
      flap_en_q    <= flap_en_d;
      gravity_en_q <= gravity_en_d;
      scroll_en_q  <= scroll_en_d;
      spawn_en_q   <= spawn_en_d;
      hs_commit_q  <= hs_commit_d;
      blank_q      <= blank_d;
`ifdef SEQ_SPEEDUP_EN
      period_q     <= period_d;
      speed_cnt_q  <= speed_cnt_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    st_d         = st_q;
    grav_d       = grav_q;
    scroll_d     = scroll_q;
    spawn_d      = spawn_q;
    hold_d       = hold_q;
    blink_d      = blink_q;
    blank_d      = blank_q;
    flap_en_d    = 1'b0;
    gravity_en_d = 1'b0;
    scroll_en_d  = 1'b0;
    spawn_en_d   = 1'b0;
    hs_commit_d  = 1'b0;
`ifdef SEQ_SPEEDUP_EN
    period_d     = period_q;
    speed_cnt_d  = speed_cnt_q;
`endif

    case (st_q)
      IDLE: begin
        // Round counters sit at zero; the start flap is consumed here.
        grav_d   = '0;
        scroll_d = '0;
        spawn_d  = '0;
        hold_d   = '0;
        blink_d  = '0;
        blank_d  = 1'b0;
`ifdef SEQ_SPEEDUP_EN
        period_d    = SW'(SCROLL_DIV);
        speed_cnt_d = '0;
`endif
        if (bus.flap) st_d = PLAY;
      end

      PLAY: begin
        if (crash) begin
          // Crash wins over pause and flap; tick counters freeze so the
          // crash frame stays on screen.
          st_d        = OVER;
          hs_commit_d = 1'b1;
          hold_d      = '0;
          blink_d     = '0;
          blank_d     = 1'b0;
        end else if (bus.pause_sw) begin
          st_d = PAUSED;
        end else begin
          flap_en_d = bus.flap;

          if (grav_q == GW'(GRAVITY_DIV - 1)) begin
            grav_d       = '0;
            gravity_en_d = 1'b1;
          end else begin
            grav_d = grav_q + GW'(1);
          end

          if (scroll_q == scroll_last) begin
            scroll_d    = '0;
            scroll_en_d = 1'b1;
            if (spawn_q == PW'(SPAWN_DIV - 1)) begin
              spawn_d    = '0;
              spawn_en_d = 1'b1;
`ifdef SEQ_SPEEDUP_EN
              // Every eighth spawn shortens the scroll period by one.
              speed_cnt_d = speed_cnt_q + 3'd1;
              if (speed_cnt_q == 3'd7 && period_q > SW'(SCROLL_DIV / 2))
                period_d = period_q - SW'(1);
`endif
            end else begin
              spawn_d = spawn_q + PW'(1);
            end
          end else begin
            scroll_d = scroll_q + SW'(1);
          end
        end
      end

      PAUSED: begin
        // Counters hold so play resumes without losing tick phase.
        if (!bus.pause_sw) st_d = PLAY;
      end

      OVER: begin
        if (bus.flap && hold_q == HW'(OVER_HOLD - 1)) begin
          st_d     = IDLE;
          blank_d  = 1'b0;
          grav_d   = '0;
          scroll_d = '0;
          spawn_d  = '0;
          hold_d   = '0;
          blink_d  = '0;
        end else begin
          if (hold_q != HW'(OVER_HOLD - 1)) hold_d = hold_q + HW'(1);
          if (blink_q == BW'(BLINK_DIV - 1)) begin
            blink_d = '0;
            blank_d = ~blank_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
      end

      default: st_d = IDLE;
    endcase

    round_clr_d = (st_d == IDLE);
  end

  assign bus.state      = st_q;
  assign bus.round_clr  = round_clr_q;
  assign bus.flap_en    = flap_en_q;
  assign bus.gravity_en = gravity_en_q;
  assign bus.scroll_en  = scroll_en_q;
  assign bus.spawn_en   = spawn_en_q;
  assign bus.hs_commit  = hs_commit_q;
  assign bus.blank      = blank_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
// Self-checking bench for game_sequencer with small parameters
// (GRAVITY_DIV=4, SCROLL_DIV=6, SPAWN_DIV=3, OVER_HOLD=10, BLINK_DIV=2).
// Output vectors are packed as {state[1:0], round_clr, flap_en, gravity_en,
// scroll_en, spawn_en, hs_commit, blank}.
// ---------------------------------------------------------------------------
module tb_game_sequencer;
  localparam int GD  = 4;
  localparam int SD  = 6;
  localparam int SPD = 3;
  localparam int OH  = 10;
  localparam int BD  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_sequencer_if bus ();

  game_sequencer #(
    .GRAVITY_DIV (GD),
    .SCROLL_DIV  (SD),
    .SPAWN_DIV   (SPD),
    .OVER_HOLD   (OH),
    .BLINK_DIV   (BD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.state, bus.round_clr, bus.flap_en, bus.gravity_en,
            bus.scroll_en, bus.spawn_en, bus.hs_commit, bus.blank};
  endfunction

  // Reference model: tracks game rules with elapsed-cycle arithmetic.
  int m_state;
  int g_n, s_ph, scrolls, spawns, over_n;
  bit m_rc, m_fe, m_ge, m_se, m_spe, m_hs, m_bl;

  function automatic logic [8:0] model_vec();
    return {2'(m_state), m_rc, m_fe, m_ge, m_se, m_spe, m_hs, m_bl};
  endfunction

  task automatic new_round();
    g_n = 0; s_ph = 0; scrolls = 0; spawns = 0; over_n = 0;
  endtask

  task automatic model_step(input bit r, input bit f, input bit p, input bit c, input bit o);
    int period;
    m_fe = 0; m_ge = 0; m_se = 0; m_spe = 0; m_hs = 0;
    if (!r) begin
      m_state = 0; m_bl = 0; new_round();
    end else begin
      case (m_state)
        0: if (f) m_state = 1;
        1: begin
          if (c || o) begin
            m_state = 3; m_hs = 1; over_n = 0; m_bl = 0;
          end else if (p) begin
            m_state = 2;
          end else begin
            m_fe = f;
            g_n++;
            m_ge = (g_n % GD == 0);
            period = SD;
`ifdef SEQ_SPEEDUP_EN
            period = SD - spawns / 8;
            if (period < SD / 2) period = SD / 2;
`endif
            s_ph++;
            if (s_ph == period) begin
              s_ph = 0; m_se = 1; scrolls++;
              if (scrolls % SPD == 0) begin m_spe = 1; spawns++; end
            end
          end
        end
        2: if (!p) m_state = 1;
        default: begin
          if (f && over_n >= OH - 1) begin
            m_state = 0; m_bl = 0; new_round();
          end else begin
            over_n++;
            m_bl = ((over_n / BD) % 2) == 1;
          end
        end
      endcase
    end
    m_rc = (m_state == 0);
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit r, input bit f, input bit p, input bit c, input bit o);
    reset = r; bus.flap = f; bus.pause_sw = p; bus.collide = c; bus.out_of_bounds = o;
    @(posedge clk);
    #1;
    model_step(r, f, p, c, o);
  endtask

  typedef struct {
    logic [4:0] in;   // {reset, flap, pause_sw, collide, out_of_bounds}
    logic [8:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] in, input logic [1:0] st, input logic [6:0] fl);
    vec_t v;
    v.in  = in;
    v.exp = {st, fl};   // fl = {rc, fe, ge, se, spe, hs, bl}
    return v;
  endfunction

  vec_t tbl [38];

  initial begin
    int ng, ns, nsp, iv, last, cyc, spn;
    bit pause_lvl, r, f, c, o;
    bit c8, c24, c32, hit;

    reset = 1'b0; bus.flap = 1'b0; bus.pause_sw = 1'b0;
    bus.collide = 1'b0; bus.out_of_bounds = 1'b0;
    m_state = 0; m_bl = 0; new_round();

    // Directed table: reset, start, flap gating, crash priority, blink, hold.
    tbl[0]  = mk(5'b00000, 2'd0, 7'b1000000);
    tbl[1]  = mk(5'b00000, 2'd0, 7'b1000000);
    tbl[2]  = mk(5'b00000, 2'd0, 7'b1000000);
    tbl[3]  = mk(5'b10000, 2'd0, 7'b1000000);
    tbl[4]  = mk(5'b11000, 2'd1, 7'b0000000);  // start flap consumed
    tbl[5]  = mk(5'b10000, 2'd1, 7'b0000000);
    tbl[6]  = mk(5'b11000, 2'd1, 7'b0100000);  // flap_en
    tbl[7]  = mk(5'b10000, 2'd1, 7'b0000000);
    tbl[8]  = mk(5'b10000, 2'd1, 7'b0010000);  // first gravity tick
    tbl[9]  = mk(5'b11110, 2'd3, 7'b0000010);  // crash beats pause and flap
    tbl[10] = mk(5'b10000, 2'd3, 7'b0000000);
    tbl[11] = mk(5'b10100, 2'd3, 7'b0000001);  // pause ignored in OVER
    tbl[12] = mk(5'b10000, 2'd3, 7'b0000001);
    tbl[13] = mk(5'b10000, 2'd3, 7'b0000000);
    tbl[14] = mk(5'b10000, 2'd3, 7'b0000000);
    tbl[15] = mk(5'b11000, 2'd3, 7'b0000001);  // flap in OVER cycle 5 ignored
    tbl[16] = mk(5'b10000, 2'd3, 7'b0000001);
    tbl[17] = mk(5'b10000, 2'd3, 7'b0000000);
    tbl[18] = mk(5'b10000, 2'd3, 7'b0000000);
    tbl[19] = mk(5'b10000, 2'd3, 7'b0000001);
    tbl[20] = mk(5'b10000, 2'd3, 7'b0000001);
    tbl[21] = mk(5'b10000, 2'd3, 7'b0000000);
    tbl[22] = mk(5'b11000, 2'd0, 7'b1000000);  // flap in OVER cycle 12 -> IDLE
    tbl[23] = mk(5'b10000, 2'd0, 7'b1000000);
    tbl[24] = mk(5'b10100, 2'd0, 7'b1000000);  // pause ignored in IDLE
    tbl[25] = mk(5'b10010, 2'd0, 7'b1000000);  // collide ignored in IDLE
    tbl[26] = mk(5'b11010, 2'd1, 7'b0000000);
    tbl[27] = mk(5'b10010, 2'd3, 7'b0000010);
    tbl[28] = mk(5'b00000, 2'd0, 7'b1000000);  // reset in OVER cycle 0
    tbl[29] = mk(5'b11000, 2'd1, 7'b0000000);
    tbl[30] = mk(5'b00010, 2'd0, 7'b1000000);  // reset drops pending hs_commit
    tbl[31] = mk(5'b10000, 2'd0, 7'b1000000);
    tbl[32] = mk(5'b11000, 2'd1, 7'b0000000);
    tbl[33] = mk(5'b11100, 2'd2, 7'b0000000);  // pause, flap suppressed
    tbl[34] = mk(5'b10110, 2'd2, 7'b0000000);  // collide ignored while paused
    tbl[35] = mk(5'b10000, 2'd1, 7'b0000000);
    tbl[36] = mk(5'b10001, 2'd3, 7'b0000010);  // out_of_bounds crash
    tbl[37] = mk(5'b00000, 2'd0, 7'b1000000);

    for (int i = 0; i < 38; i++) begin
      step(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // Tick spacing over 36 PLAY cycles.
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    ng = 0; ns = 0; nsp = 0;
    for (int i = 1; i <= 36; i++) begin
      step(1, 0, 0, 0, 0);
      ng  += int'(bus.gravity_en);
      ns  += int'(bus.scroll_en);
      nsp += int'(bus.spawn_en);
      check($sformatf("tick%0d", i), 9'({bus.gravity_en, bus.scroll_en, bus.spawn_en}),
            9'({i % 4 == 0, i % 6 == 0, i % 18 == 0}));
    end
    check("n_gravity", 9'(ng), 9'd9);
    check("n_scroll", 9'(ns), 9'd6);
    check("n_spawn", 9'(nsp), 9'd2);

    // Pause at scroll phase 3 for 20 cycles, then resume without phase loss.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 1, 0, 0);
      check($sformatf("paused%0d", i), 9'({bus.state, bus.flap_en, bus.gravity_en,
            bus.scroll_en, bus.spawn_en}), 9'({2'd2, 4'b0000}));
    end
    step(1, 0, 0, 0, 0);
    check("resume_r0", dut_vec(), {2'd1, 7'b0000000});
    step(1, 0, 0, 0, 0);
    check("resume_r1", dut_vec(), {2'd1, 7'b0010000});
    step(1, 0, 0, 0, 0);
    check("resume_r2", dut_vec(), {2'd1, 7'b0000000});
    step(1, 0, 0, 0, 0);
    check("resume_r3", dut_vec(), {2'd1, 7'b0001000});

`ifdef SEQ_SPEEDUP_EN
    // Scroll period shrinks every 8 spawns down to SD/2, restores on a new round.
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    spn = 0; last = 0; cyc = 0; c8 = 0; c24 = 0; c32 = 0;
    for (int i = 0; i < 2000 && !c32; i++) begin
      step(1, 0, 0, 0, 0);
      cyc++;
      if (bus.scroll_en) begin
        iv = cyc - last;
        last = cyc;
        if (spn == 8 && !c8)   begin check("speed_after8", 9'(iv), 9'd5); c8 = 1; end
        if (spn == 24 && !c24) begin check("speed_after24", 9'(iv), 9'd3); c24 = 1; end
        if (spn == 32 && !c32) begin check("speed_floor", 9'(iv), 9'd3); c32 = 1; end
        if (bus.spawn_en) spn++;
      end
    end
    if (!c32) check("speed_budget", 9'(spn), 9'd32);
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < OH; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("speed_idle", 9'(bus.state), 9'd0);
    step(1, 1, 0, 0, 0);
    hit = 0;
    for (int i = 1; i <= 20 && !hit; i++) begin
      step(1, 0, 0, 0, 0);
      if (bus.scroll_en) begin check("speed_restored", 9'(i), 9'd6); hit = 1; end
    end
    if (!hit) check("speed_restored_seen", 9'(hit), 9'd1);
`endif

    // Randomized play against the reference model.
    step(0, 0, 0, 0, 0);
    pause_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      f = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) pause_lvl = ~pause_lvl;
      c = ($urandom_range(0, 59) == 0);
      o = ($urandom_range(0, 99) == 0);
      step(r, f, pause_lvl, c, o);
      check($sformatf("rand%0d", i), dut_vec(), model_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game controller for the 8x8 Flappy Bird datapath. It replaces the free-running tick counters and the ad-hoc reset OR-ing with one state machine (IDLE/PLAY/PAUSED/OVER). It produces the gravity, scroll and barrier-spawn enables, a round-clear level for the bird, column and score blocks, and a gated flap. It also drives a one-shot high-score commit and a blink control for the game-over screen. It runs on the divided system clock.

Parameters:
GRAVITY_DIV, 8, clk cycles per gravity_en pulse (>=2)
SCROLL_DIV, 24, clk cycles per scroll_en pulse (>=2)
SPAWN_DIV, 4, scroll_en pulses per spawn_en pulse (>=1)
OVER_HOLD, 64, clk cycles in OVER before a flap is accepted (>=1)
BLINK_DIV, 8, clk cycles per blank toggle in OVER (>=1)

Ports:
clk  input  1  divided system clock
reset  input  1  synchronous, active-low reset (0 = reset)
flap  input  1  one-cycle flap pulse from the edge detector
pause_sw  input  1  synchronized pause switch level
collide  input  1  bird/barrier overlap
out_of_bounds  input  1  bird left the field
state  output  2  0=IDLE, 1=PLAY, 2=PAUSED, 3=OVER
round_clr  output  1  level; holds the bird, columns and score in their start state
flap_en  output  1  gated flap to the bird column
gravity_en  output  1  one-cycle gravity tick
scroll_en  output  1  one-cycle column-shift tick
spawn_en  output  1  one-cycle new-barrier tick; coincides with a scroll_en
hs_commit  output  1  one-cycle pulse to latch the high score
blank  output  1  display blank during OVER blink

Behaviour:
- One clock; reset is synchronous and active-low. When reset==0 at a clk edge:
  - state=IDLE, round_clr=1, blank=0.
  - All pulses are 0 and all counters are 0.
- All outputs are registered. Pulse outputs have 1-cycle latency from the cause.
- IDLE:
  - round_clr=1; counters held at 0.
  - A flap moves to PLAY. The start flap is consumed: flap_en stays 0.
  - round_clr=0 from the first PLAY cycle.
- PLAY:
  - gravity counter runs 0..GRAVITY_DIV-1. gravity_en=1 the cycle after it wraps.
  - scroll counter behaves the same way with SCROLL_DIV.
  - spawn counter increments on each scroll wrap. spawn_en is asserted together with scroll_en when the spawn counter wraps at SPAWN_DIV.
  - flap_en is the registered flap, suppressed if collide or out_of_bounds is high in the same cycle.
  - Priority order: collide|out_of_bounds -> OVER, then pause_sw=1 -> PAUSED.
- PAUSED:
  - All counters hold their values; no enables and no flap_en.
  - collide and out_of_bounds are ignored.
  - pause_sw=0 -> PLAY. Counters resume from the held values, so no phase loss.
- OVER:
  - hs_commit=1 for exactly the first OVER cycle.
  - Tick counters freeze and round_clr=0, so the crash frame stays visible.
  - The hold counter counts up to OVER_HOLD-1 and saturates.
  - blank toggles every BLINK_DIV cycles, starting at 0.
  - A flap before the hold saturates is ignored.
  - A flap after saturation -> IDLE, with blank=0 and hs_commit=0.
- pause_sw high in IDLE or OVER has no effect.
- A reset mid-game from any state returns to IDLE on the next edge. A pending hs_commit is dropped.
- Counter widths are $clog2(param)+1. No overflow is possible.

Optional Feature:
SEQ_SPEEDUP_EN
- Defined:
  - The effective scroll period starts at SCROLL_DIV.
  - It decrements by 1 after every 8 spawn_en pulses, with a floor of SCROLL_DIV/2.
  - It returns to SCROLL_DIV whenever round_clr=1.
- Undefined: the scroll period is constant at SCROLL_DIV and the extra logic is absent.

Test Plan:
All scenarios use GRAVITY_DIV=4, SCROLL_DIV=6, SPAWN_DIV=3, OVER_HOLD=10, BLINK_DIV=2.
- Reset: hold reset=0 for 3 cycles -> state=0, round_clr=1, all pulses 0. Release, then flap -> state=1 next cycle, flap_en never 1, round_clr=0.
- Ticks: in PLAY for 36 cycles -> gravity_en has 9 single-cycle pulses spaced 4 apart; scroll_en has 6 pulses spaced 6 apart; spawn_en fires with scroll pulses 3 and 6 only.
- Pause: pause_sw=1 at cycle 3 of a scroll period for 20 cycles -> state=2, no enables. On release, the next scroll_en comes exactly 3 cycles later.
- Crash priority: collide=1, pause_sw=1 and flap=1 in the same PLAY cycle -> state=3, flap_en=0, hs_commit high for exactly 1 cycle, blank sequence 0,0,1,1,0,...
- Game-over hold: flap at OVER cycle 5 -> ignored. Flap at cycle 12 -> state=0, round_clr=1, blank=0.
- Reset mid-OVER at cycle 0 -> no hs_commit pulse, state=0 next edge. With SEQ_SPEEDUP_EN, 8 spawns -> scroll period becomes 5, floor is 3, and it resets to 6 after returning to IDLE.
